// File: rtl/ysyx_decode_stage.sv
// RV32I decode stage: combinational decode of the offered word, captured into an
// output register with a one-entry skid buffer and a sticky halt on ebreak.
module ysyx_decode_stage #(
    parameter int unsigned XLEN           = 32,
    parameter bit          HALT_ON_EBREAK = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic            out_rf_wr_en,
    output logic [1:0]      out_rf_wr_sel,
    output logic            out_do_jump,
    output logic [2:0]      out_br_type,
    output logic            out_alu_a_sel,
    output logic            out_alu_b_sel,
    output logic [3:0]      out_alu_ctrl,
    output logic [2:0]      out_dm_rd_sel,
    output logic [1:0]      out_dm_wr_sel,
    output logic            out_illegal,
    output logic            out_ecall,
    output logic            out_ebreak,
    output logic            halted
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] WR_PC4 = 2'b01;
    localparam logic [1:0] WR_ALU = 2'b10;
    localparam logic [1:0] WR_MEM = 2'b11;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1101;
    localparam logic [3:0] ALU_PASSB = 4'b1110;

    localparam logic [6:0] F7_ZERO = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            rf_wr_en;
        logic [1:0]      rf_wr_sel;
        logic            do_jump;
        logic [2:0]      br_type;
        logic            alu_a_sel;
        logic            alu_b_sel;
        logic [3:0]      alu_ctrl;
        logic [2:0]      dm_rd_sel;
        logic [1:0]      dm_wr_sel;
        logic            illegal;
        logic            ecall;
        logic            ebreak;
    } dec_t;

    logic [6:0]      opcode;
    logic [4:0]      rd_f;
    logic [2:0]      f3;
    logic [4:0]      rs1_f;
    logic [4:0]      rs2_f;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic            ill;
    dec_t            dec;

    dec_t            or_q, or_d;
    dec_t            sk_q, sk_d;
    logic            or_valid_q, or_valid_d;
    logic            sk_valid_q, sk_valid_d;
    logic            halted_q, halted_d;
    logic            accept;
    logic            consume;

    assign opcode = in_inst[6:0];
    assign rd_f   = in_inst[11:7];
    assign f3     = in_inst[14:12];
    assign rs1_f  = in_inst[19:15];
    assign rs2_f  = in_inst[24:20];
    assign f7     = in_inst[31:25];

    // Immediates, sign-extended from bit 31 to XLEN
    assign imm_i = XLEN'($signed(in_inst[31:20]));
    assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
    assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));

    always_comb begin
        dec = '0;
        ill = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec.rd        = rd_f;
                dec.imm       = imm_u;
                dec.rf_wr_en  = 1'b1;
                dec.rf_wr_sel = WR_ALU;
                dec.alu_b_sel = 1'b1;
                dec.alu_ctrl  = ALU_PASSB;
            end
            OPC_AUIPC: begin
                dec.rd        = rd_f;
                dec.imm       = imm_u;
                dec.rf_wr_en  = 1'b1;
                dec.rf_wr_sel = WR_ALU;
                dec.alu_b_sel = 1'b1;
                dec.alu_ctrl  = ALU_ADD;
            end
            OPC_JAL: begin
                dec.rd        = rd_f;
                dec.imm       = imm_j;
                dec.rf_wr_en  = 1'b1;
                dec.rf_wr_sel = WR_PC4;
                dec.do_jump   = 1'b1;
                dec.alu_b_sel = 1'b1;
                dec.alu_ctrl  = ALU_ADD;
            end
            OPC_JALR: begin
                dec.rd        = rd_f;
                dec.rs1       = rs1_f;
                dec.imm       = imm_i;
                dec.rf_wr_en  = 1'b1;
                dec.rf_wr_sel = WR_PC4;
                dec.do_jump   = 1'b1;
                dec.alu_a_sel = 1'b1;
                dec.alu_b_sel = 1'b1;
                dec.alu_ctrl  = ALU_ADD;
                if (f3 != 3'b000) ill = 1'b1;
            end
            OPC_BRANCH: begin
                // ALU computes pc+imm as the target; comparison is carried in br_type
                dec.rs1       = rs1_f;
                dec.rs2       = rs2_f;
                dec.imm       = imm_b;
                dec.alu_b_sel = 1'b1;
                dec.alu_ctrl  = ALU_ADD;
                dec.br_type   = f3[2] ? f3 : {2'b01, f3[0]};
                if (f3[2:1] == 2'b01) ill = 1'b1;
            end
            OPC_LOAD: begin
                dec.rd        = rd_f;
                dec.rs1       = rs1_f;
                dec.imm       = imm_i;
                dec.rf_wr_en  = 1'b1;
                dec.rf_wr_sel = WR_MEM;
                dec.alu_a_sel = 1'b1;
                dec.alu_b_sel = 1'b1;
                dec.alu_ctrl  = ALU_ADD;
                case (f3)
                    3'b000:  dec.dm_rd_sel = 3'b001;
                    3'b001:  dec.dm_rd_sel = 3'b011;
                    3'b010:  dec.dm_rd_sel = 3'b101;
                    3'b100:  dec.dm_rd_sel = 3'b010;
                    3'b101:  dec.dm_rd_sel = 3'b100;
                    default: ill = 1'b1;
                endcase
            end
            OPC_STORE: begin
                dec.rs1       = rs1_f;
                dec.rs2       = rs2_f;
                dec.imm       = imm_s;
                dec.alu_a_sel = 1'b1;
                dec.alu_b_sel = 1'b1;
                dec.alu_ctrl  = ALU_ADD;
                case (f3)
                    3'b000:  dec.dm_wr_sel = 2'b01;
                    3'b001:  dec.dm_wr_sel = 2'b10;
                    3'b010:  dec.dm_wr_sel = 2'b11;
                    default: ill = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                dec.rd        = rd_f;
                dec.rs1       = rs1_f;
                dec.imm       = imm_i;
                dec.rf_wr_en  = 1'b1;
                dec.rf_wr_sel = WR_ALU;
                dec.alu_a_sel = 1'b1;
                dec.alu_b_sel = 1'b1;
                dec.alu_ctrl  = {1'b0, f3};
                if (f3 == 3'b001 && f7 != F7_ZERO) ill = 1'b1;
                if (f3 == 3'b101) begin
                    if (f7 == F7_ALT)        dec.alu_ctrl = ALU_SRA;
                    else if (f7 != F7_ZERO) ill = 1'b1;
                end
            end
            OPC_OP: begin
                dec.rd        = rd_f;
                dec.rs1       = rs1_f;
                dec.rs2       = rs2_f;
                dec.rf_wr_en  = 1'b1;
                dec.rf_wr_sel = WR_ALU;
                dec.alu_a_sel = 1'b1;
                if (f7 == F7_ZERO) begin
                    dec.alu_ctrl = {1'b0, f3};
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    dec.alu_ctrl = ALU_SUB;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    dec.alu_ctrl = ALU_SRA;
                end else begin
                    ill = 1'b1;
                end
            end
            OPC_SYSTEM: begin
                if (in_inst == 32'h0000_0073)      dec.ecall  = 1'b1;
                else if (in_inst == 32'h0010_0073) dec.ebreak = 1'b1;
                else                               ill = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        if (dec.rd == 5'd0) dec.rf_wr_en = 1'b0;
        if (ill) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
        dec.pc = in_pc;
    end

    assign in_ready = !sk_valid_q && !halted_q;
    assign accept   = in_valid && in_ready && !flush;
    assign consume  = or_valid_q && out_ready;

    // OR/SK movement; flush wins over consume and accept
    always_comb begin
        or_d       = or_q;
        sk_d       = sk_q;
        or_valid_d = or_valid_q;
        sk_valid_d = sk_valid_q;
        halted_d   = halted_q;
        if (flush) begin
            or_valid_d = 1'b0;
            sk_valid_d = 1'b0;
        end else begin
            if (consume) begin
                if (sk_valid_q) begin
                    or_d       = sk_q;
                    sk_valid_d = 1'b0;
                end else if (accept) begin
                    or_d = dec;
                end else begin
                    or_valid_d = 1'b0;
                end
            end else if (accept) begin
                if (!or_valid_q) begin
                    or_d       = dec;
                    or_valid_d = 1'b1;
                end else begin
                    sk_d       = dec;
                    sk_valid_d = 1'b1;
                end
            end
            if (accept && dec.ebreak && HALT_ON_EBREAK) halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            or_q       <= '0;
            sk_q       <= '0;
            or_valid_q <= 1'b0;
            sk_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            or_q       <= or_d;
            sk_q       <= sk_d;
            or_valid_q <= or_valid_d;
            sk_valid_q <= sk_valid_d;
            halted_q   <= halted_d;
        end
    end

    assign out_valid     = or_valid_q;
    assign out_pc        = or_q.pc;
    assign out_rs1       = or_q.rs1;
    assign out_rs2       = or_q.rs2;
    assign out_rd        = or_q.rd;
    assign out_imm       = or_q.imm;
    assign out_rf_wr_en  = or_q.rf_wr_en;
    assign out_rf_wr_sel = or_q.rf_wr_sel;
    assign out_do_jump   = or_q.do_jump;
    assign out_br_type   = or_q.br_type;
    assign out_alu_a_sel = or_q.alu_a_sel;
    assign out_alu_b_sel = or_q.alu_b_sel;
    assign out_alu_ctrl  = or_q.alu_ctrl;
    assign out_dm_rd_sel = or_q.dm_rd_sel;
    assign out_dm_wr_sel = or_q.dm_wr_sel;
    assign out_illegal   = or_q.illegal;
    assign out_ecall     = or_q.ecall;
    assign out_ebreak    = or_q.ebreak;
    assign halted        = halted_q;

endmodule

// File: tb/tb_ysyx_decode_stage.sv
// Directed bench for ysyx_decode_stage: decode vectors, skid backpressure, flush,
// mid-stream reset and ebreak halt.
module tb_ysyx_decode_stage;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_rs1, out_rs2, out_rd;
    logic [XLEN-1:0] out_imm;
    logic            out_rf_wr_en;
    logic [1:0]      out_rf_wr_sel;
    logic            out_do_jump;
    logic [2:0]      out_br_type;
    logic            out_alu_a_sel, out_alu_b_sel;
    logic [3:0]      out_alu_ctrl;
    logic [2:0]      out_dm_rd_sel;
    logic [1:0]      out_dm_wr_sel;
    logic            out_illegal, out_ecall, out_ebreak;
    logic            halted;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ysyx_decode_stage #(.XLEN(XLEN), .HALT_ON_EBREAK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_rf_wr_en(out_rf_wr_en), .out_rf_wr_sel(out_rf_wr_sel),
        .out_do_jump(out_do_jump), .out_br_type(out_br_type),
        .out_alu_a_sel(out_alu_a_sel), .out_alu_b_sel(out_alu_b_sel),
        .out_alu_ctrl(out_alu_ctrl), .out_dm_rd_sel(out_dm_rd_sel),
        .out_dm_wr_sel(out_dm_wr_sel), .out_illegal(out_illegal),
        .out_ecall(out_ecall), .out_ebreak(out_ebreak), .halted(halted)
    );

    // Control fields gathered in one vector, order matches mk_ctl
    logic [20:0] obs_ctl;
    assign obs_ctl = {out_rf_wr_en, out_rf_wr_sel, out_do_jump, out_br_type,
                      out_alu_a_sel, out_alu_b_sel, out_alu_ctrl,
                      out_dm_rd_sel, out_dm_wr_sel, out_illegal, out_ecall, out_ebreak};

    function automatic logic [20:0] mk_ctl(input logic we, input logic [1:0] ws, input logic j,
                                           input logic [2:0] br, input logic a, input logic b,
                                           input logic [3:0] alu, input logic [2:0] dr,
                                           input logic [1:0] dw, input logic il,
                                           input logic ec, input logic eb);
        return {we, ws, j, br, a, b, alu, dr, dw, il, ec, eb};
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic [20:0] ctl;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
    } vec_t;

    vec_t rows[$];

    task automatic add_row(input logic [31:0] inst, input logic [20:0] ctl, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        vec_t v;
        v.inst = inst; v.ctl = ctl; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        rows.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic offer(input logic [31:0] inst, input logic [XLEN-1:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0;
        tick(); tick();
        rst_n = 1'b1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
        n_tests++; if (obs_ctl !== 21'd0) begin n_fail++; $display("FAIL reset_ctl got %h want 0", obs_ctl); end
        n_tests++; if (out_pc !== '0 || out_imm !== '0) begin n_fail++; $display("FAIL reset_pc_imm got %h/%h want 0/0", out_pc, out_imm); end
    endtask

    task automatic test_decode();
        logic [20:0] ill_c;
        ill_c = mk_ctl(0, 2'b00, 0, 3'b000, 0, 0, 4'b0000, 3'b000, 2'b00, 1, 0, 0);
        add_row(32'h0050_0093, mk_ctl(1, 2'b10, 0, 3'b000, 1, 1, 4'b0000, 3'b000, 2'b00, 0, 0, 0), 5'd1, 5'd0, 5'd0, 32'h0000_0005);
        add_row(32'hFE20_9EE3, mk_ctl(0, 2'b00, 0, 3'b011, 0, 1, 4'b0000, 3'b000, 2'b00, 0, 0, 0), 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
        add_row(32'h1234_5537, mk_ctl(1, 2'b10, 0, 3'b000, 0, 1, 4'b1110, 3'b000, 2'b00, 0, 0, 0), 5'd10, 5'd0, 5'd0, 32'h1234_5000);
        add_row(32'h0000_1297, mk_ctl(1, 2'b10, 0, 3'b000, 0, 1, 4'b0000, 3'b000, 2'b00, 0, 0, 0), 5'd5, 5'd0, 5'd0, 32'h0000_1000);
        add_row(32'h0080_00EF, mk_ctl(1, 2'b01, 1, 3'b000, 0, 1, 4'b0000, 3'b000, 2'b00, 0, 0, 0), 5'd1, 5'd0, 5'd0, 32'h0000_0008);
        add_row(32'h0000_8067, mk_ctl(0, 2'b01, 1, 3'b000, 1, 1, 4'b0000, 3'b000, 2'b00, 0, 0, 0), 5'd0, 5'd1, 5'd0, 32'h0000_0000);
        add_row(32'hFF81_2283, mk_ctl(1, 2'b11, 0, 3'b000, 1, 1, 4'b0000, 3'b101, 2'b00, 0, 0, 0), 5'd5, 5'd2, 5'd0, 32'hFFFF_FFF8);
        add_row(32'h0003_C303, mk_ctl(1, 2'b11, 0, 3'b000, 1, 1, 4'b0000, 3'b010, 2'b00, 0, 0, 0), 5'd6, 5'd7, 5'd0, 32'h0000_0000);
        add_row(32'h0032_2623, mk_ctl(0, 2'b00, 0, 3'b000, 1, 1, 4'b0000, 3'b000, 2'b11, 0, 0, 0), 5'd0, 5'd4, 5'd3, 32'h0000_000C);
        add_row(32'h4020_81B3, mk_ctl(1, 2'b10, 0, 3'b000, 1, 0, 4'b1000, 3'b000, 2'b00, 0, 0, 0), 5'd3, 5'd1, 5'd2, 32'h0000_0000);
        add_row(32'h4033_5293, mk_ctl(1, 2'b10, 0, 3'b000, 1, 1, 4'b1101, 3'b000, 2'b00, 0, 0, 0), 5'd5, 5'd6, 5'd0, 32'h0000_0403);
        add_row(32'h0000_0013, mk_ctl(0, 2'b10, 0, 3'b000, 1, 1, 4'b0000, 3'b000, 2'b00, 0, 0, 0), 5'd0, 5'd0, 5'd0, 32'h0000_0000);
        add_row(32'h0020_F463, mk_ctl(0, 2'b00, 0, 3'b111, 0, 1, 4'b0000, 3'b000, 2'b00, 0, 0, 0), 5'd0, 5'd1, 5'd2, 32'h0000_0008);
        add_row(32'h0000_0073, mk_ctl(0, 2'b00, 0, 3'b000, 0, 0, 4'b0000, 3'b000, 2'b00, 0, 1, 0), 5'd0, 5'd0, 5'd0, 32'h0000_0000);
        add_row(32'h0000_0000, ill_c, 5'd0, 5'd0, 5'd0, 32'h0);
        add_row(32'h4000_1013, ill_c, 5'd0, 5'd0, 5'd0, 32'h0);
        add_row(32'h0000_10E7, ill_c, 5'd0, 5'd0, 5'd0, 32'h0);
        add_row(32'h3000_1073, ill_c, 5'd0, 5'd0, 5'd0, 32'h0);
        add_row(32'h0000_000F, ill_c, 5'd0, 5'd0, 5'd0, 32'h0);
        add_row(32'h0200_0033, ill_c, 5'd0, 5'd0, 5'd0, 32'h0);
        add_row(32'h0020_0073, ill_c, 5'd0, 5'd0, 5'd0, 32'h0);
        add_row(32'h0000_2063, ill_c, 5'd0, 5'd0, 5'd0, 32'h0);
        out_ready = 1'b1;
        // Rows stream back to back: each one must appear the cycle after it is offered
        foreach (rows[i]) begin
            logic [XLEN-1:0] pc;
            pc = XLEN'(32'h8000_0000) + XLEN'(4 * i);
            n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL dec_in_ready[%0d] got %b want 1", i, in_ready); end
            offer(rows[i].inst, pc);
            tick();
            n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dec_valid[%0d] got %b want 1", i, out_valid); end
            n_tests++; if (out_pc !== pc) begin n_fail++; $display("FAIL dec_pc[%0d] got %h want %h", i, out_pc, pc); end
            n_tests++; if (obs_ctl !== rows[i].ctl) begin n_fail++; $display("FAIL dec_ctl[%0d] inst %h got %h want %h", i, rows[i].inst, obs_ctl, rows[i].ctl); end
            if (rows[i].ctl[2] == 1'b0) begin
                n_tests++; if ({out_rd, out_rs1, out_rs2} !== {rows[i].rd, rows[i].rs1, rows[i].rs2}) begin
                    n_fail++; $display("FAIL dec_regs[%0d] got %0d/%0d/%0d want %0d/%0d/%0d", i, out_rd, out_rs1, out_rs2, rows[i].rd, rows[i].rs1, rows[i].rs2); end
                n_tests++; if (out_imm !== rows[i].imm) begin n_fail++; $display("FAIL dec_imm[%0d] got %h want %h", i, out_imm, rows[i].imm); end
            end
        end
        in_valid = 1'b0;
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dec_drain got %b want 0", out_valid); end
        n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL ecall_no_halt got %b want 0", halted); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        offer(32'h0010_0093, 32'h100);
        tick();
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready1 got %b want 1", in_ready); end
        offer(32'h0020_0113, 32'h104);
        tick();
        offer(32'h0030_0193, 32'h108);
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full got %b want 0", in_ready); end
        tick();
        n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin n_fail++; $display("FAIL bp_hold got %b/%h want 1/100", out_valid, out_pc); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_stall got %b want 0", in_ready); end
        out_ready = 1'b1;
        tick();
        n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h104 || out_rd !== 5'd2) begin n_fail++; $display("FAIL bp_second got %b/%h/%0d want 1/104/2", out_valid, out_pc, out_rd); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h108 || out_rd !== 5'd3) begin n_fail++; $display("FAIL bp_third got %b/%h/%0d want 1/108/3", out_valid, out_pc, out_rd); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        offer(32'h0010_0093, 32'h200);
        tick();
        offer(32'h0020_0113, 32'h204);
        tick();
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fl_full got %b want 0", in_ready); end
        offer(32'h0030_0193, 32'h208);
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid got %b want 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fl_ready got %b want 1", in_ready); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_ghost[%0d] got %b pc %h want 0", k, out_valid, out_pc); end
        end
        offer(32'h0040_0213, 32'h20C);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_block_accept got %b want 0", out_valid); end
        offer(32'h0050_0293, 32'h210);
        tick();
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h210 || out_rd !== 5'd5) begin n_fail++; $display("FAIL fl_resume got %b/%h/%0d want 1/210/5", out_valid, out_pc, out_rd); end
        tick();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        offer(32'h0010_0093, 32'h300);
        tick();
        offer(32'h0020_0113, 32'h304);
        tick();
        rst_n = 1'b0; out_ready = 1'b1;
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL mr_state got %b/%b want 0/1", out_valid, in_ready); end
        n_tests++; if (out_pc !== '0 || obs_ctl !== 21'd0 || out_rd !== 5'd0) begin n_fail++; $display("FAIL mr_fields got %h/%h/%0d want 0/0/0", out_pc, obs_ctl, out_rd); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_ghost got %b want 0", out_valid); end
    endtask

    task automatic test_ebreak_halt();
        out_ready = 1'b1;
        offer(32'h0010_0073, 32'h400);
        tick();
        n_tests++; if (out_valid !== 1'b1 || out_ebreak !== 1'b1 || out_ecall !== 1'b0) begin n_fail++; $display("FAIL eb_out got %b/%b/%b want 1/1/0", out_valid, out_ebreak, out_ecall); end
        n_tests++; if (halted !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL eb_halt got %b/%b want 1/0", halted, in_ready); end
        offer(32'h0050_0093, 32'h404);
        for (int k = 0; k < 4; k++) tick();
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL eb_no_accept got %b/%b want 0/0", out_valid, in_ready); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL eb_flush_keeps got %b want 1", halted); end
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_tests++; if (halted !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL eb_reset got %b/%b want 0/1", halted, in_ready); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
        test_ebreak_halt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
